// File: rtl/gift_scheduler_pkg.sv
// Shared definitions for the gift scheduler: coordinate/kind widths, the gift
// kind codes, default gift dimensions and small arithmetic helpers.
package gift_scheduler_pkg;

  localparam int COORD_W    = 10;  // screen coordinate width
  localparam int CMP_W      = 11;  // widened compare width so sums never wrap
  localparam int KIND_W     = 3;   // gift kind code width
  localparam int CNT_W      = 8;   // statistics counter width
  localparam int GIFT_W_DEF = 16;  // default gift width in pixels
  localparam int GIFT_H_DEF = 8;   // default gift height in pixels

  // Gift kind codes as seen by the effect logic.
  typedef enum logic [KIND_W-1:0] {
    KIND_INC = 3'd0,
    KIND_DEC = 3'd1,
    KIND_SPU = 3'd2,
    KIND_SPD = 3'd3,
    KIND_HID = 3'd4,
    KIND_SOT = 3'd5,
    KIND_DRP = 3'd6,
    KIND_MUL = 3'd7
  } gift_kind_e;

  // A brick break yields a gift on one draw in four.
  function automatic logic gift_won(input logic [4:0] rnd);
    return (rnd[4:3] == 2'b00);
  endfunction

  // Saturating add of a small increment to an 8-bit statistics counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] val,
                                               input logic [3:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, val} + {5'd0, inc};
    return sum[CNT_W] ? 8'hFF : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/gift_scheduler_slot.sv
// gift_slot: one falling-gift slot. Holds active/kind/x/y, applies load, fall
// step and clear (clear beats load beats step), and reports whether the gift
// overlaps the paddle and whether it has reached the floor.
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   load, load_x/y/kind   occupy the slot with a new gift
//   step                  add FALL_STEP to y
//   clear                 free the slot
//   paddle_x/y/w          paddle rectangle for the catch compare
//   active, kind, x, y    registered slot state
//   catch_hit             active gift overlaps the paddle
//   at_floor              active gift at or below FLOOR_Y
module gift_slot
  import gift_scheduler_pkg::*;
#(
  parameter int FALL_STEP = 1,
  parameter int FLOOR_Y   = 480,
  parameter int GIFT_W    = GIFT_W_DEF,
  parameter int GIFT_H    = GIFT_H_DEF,
  parameter int PADDLE_H  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic [KIND_W-1:0]  load_kind,
  input  logic               step,
  input  logic               clear,
  input  logic [COORD_W-1:0] paddle_x,
  input  logic [COORD_W-1:0] paddle_y,
  input  logic [COORD_W-1:0] paddle_w,
  output logic               active,
  output logic [KIND_W-1:0]  kind,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               catch_hit,
  output logic               at_floor
);

  logic               active_r;
  logic [KIND_W-1:0]  kind_r;
  logic [COORD_W-1:0] x_r;
  logic [COORD_W-1:0] y_r;

  logic [CMP_W-1:0] gift_bot_s;
  logic [CMP_W-1:0] gift_right_s;
  logic [CMP_W-1:0] pad_bot_s;
  logic [CMP_W-1:0] pad_right_s;

  // Slot state: clear has priority, load only ever targets a free slot.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      active_r <= 1'b0;
      kind_r   <= 3'd0;
      x_r      <= 10'd0;
      y_r      <= 10'd0;
    end else if (load) begin
      active_r <= 1'b1;
      kind_r   <= load_kind;
      x_r      <= load_x;
      y_r      <= load_y;
    end else if (step) begin
      y_r <= y_r + COORD_W'(FALL_STEP);
    end
  end

  // Rectangle edges widened by one bit so the overlap test never wraps.
  assign gift_bot_s   = {1'b0, y_r} + CMP_W'(GIFT_H);
  assign gift_right_s = {1'b0, x_r} + CMP_W'(GIFT_W);
  assign pad_bot_s    = {1'b0, paddle_y} + CMP_W'(PADDLE_H);
  assign pad_right_s  = {1'b0, paddle_x} + {1'b0, paddle_w};

  assign catch_hit = active_r
                   & (gift_bot_s >= {1'b0, paddle_y})
                   & ({1'b0, y_r} <= pad_bot_s)
                   & (gift_right_s > {1'b0, paddle_x})
                   & ({1'b0, x_r} < pad_right_s);

  assign at_floor = active_r & (y_r >= COORD_W'(FLOOR_Y));

  assign active = active_r;
  assign kind   = kind_r;
  assign x      = x_r;
  assign y      = y_r;

endmodule

// File: rtl/gift_scheduler.sv
// gift_scheduler: pool of falling power-up gifts. Turns winning brick breaks
// into gifts in the lowest free slot, drops gifts on a fall tick, grants the
// lowest catching slot to the effect valid/ack port and frees floor losses.
// Optional feature macro: GIFT_STATS_EN enables saturating caught/lost counters;
// without it caught_cnt and lost_cnt are tied to zero.
// Ports:
//   clock, reset              clock and synchronous active-high reset
//   enable                    game running; 0 freezes divider, slots, spawn, catch
//   level_clear               discard all gifts (pending effect kept)
//   spawn_req/x/y, rand_in    brick break event and its random draw
//   paddle_x/y/w              paddle rectangle
//   slot_active/kind/x/y      packed per-slot state for the renderer
//   spawn_drop                gift won with no free slot
//   effect_valid/kind/ack     caught-gift handshake to the effect logic
//   caught_cnt, lost_cnt      statistics counters
module gift_scheduler
  import gift_scheduler_pkg::*;
#(
  parameter int NSLOT     = 4,
  parameter int TICK_DIV  = 250000,
  parameter int FALL_STEP = 1,
  parameter int FLOOR_Y   = 480,
  parameter int GIFT_W    = GIFT_W_DEF,
  parameter int GIFT_H    = GIFT_H_DEF,
  parameter int PADDLE_H  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     level_clear,
  input  logic                     spawn_req,
  input  logic [COORD_W-1:0]       spawn_x,
  input  logic [COORD_W-1:0]       spawn_y,
  input  logic [4:0]               rand_in,
  input  logic [COORD_W-1:0]       paddle_x,
  input  logic [COORD_W-1:0]       paddle_y,
  input  logic [COORD_W-1:0]       paddle_w,
  output logic [NSLOT-1:0]         slot_active,
  output logic [KIND_W*NSLOT-1:0]  slot_kind,
  output logic [COORD_W*NSLOT-1:0] slot_x,
  output logic [COORD_W*NSLOT-1:0] slot_y,
  output logic                     spawn_drop,
  output logic                     effect_valid,
  output logic [KIND_W-1:0]        effect_kind,
  input  logic                     effect_ack,
  output logic [CNT_W-1:0]         caught_cnt,
  output logic [CNT_W-1:0]         lost_cnt
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0]  div_r;
  logic              tick_s;
  logic [NSLOT-1:0]  catch_s;
  logic [NSLOT-1:0]  floor_s;
  logic [NSLOT-1:0]  free_vec_s;
  logic [NSLOT-1:0]  free_oh_s;
  logic [NSLOT-1:0]  catch_oh_s;
  logic [NSLOT-1:0]  grant_oh_s;
  logic [NSLOT-1:0]  loss_s;
  logic [NSLOT-1:0]  load_s;
  logic [NSLOT-1:0]  step_s;
  logic [NSLOT-1:0]  clear_s;
  logic              grant_any_s;
  logic              port_free_s;
  logic              spawn_ok_s;
  logic              drop_s;
  logic [KIND_W-1:0] grant_kind_s;
  logic              spawn_drop_r;
  logic              effect_valid_r;
  logic [KIND_W-1:0] effect_kind_r;

  // Fall-tick divider: runs only while the game is enabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_r <= '0;
    end else if (enable) begin
      if (tick_s) begin
        div_r <= '0;
      end else begin
        div_r <= div_r + DIV_W'(1);
      end
    end
  end

  assign tick_s = enable & (div_r == DIV_W'(TICK_DIV - 1));

  // Lowest-set-bit isolation gives both priority encoders as one-hot vectors.
  // Free means free before this edge, so a slot released now is not reused.
  assign free_vec_s  = ~slot_active;
  assign free_oh_s   = free_vec_s & (~free_vec_s + NSLOT'(1));
  assign catch_oh_s  = catch_s & (~catch_s + NSLOT'(1));

  assign port_free_s = ~effect_valid_r | effect_ack;
  assign grant_oh_s  = catch_oh_s & {NSLOT{enable & ~level_clear & port_free_s}};
  assign grant_any_s = |grant_oh_s;

  // A catching but deferred gift at the floor is still lost; only the grant saves it.
  assign loss_s = floor_s & ~grant_oh_s & {NSLOT{enable & ~level_clear}};

  assign spawn_ok_s = enable & spawn_req & ~level_clear & gift_won(rand_in);
  assign drop_s     = spawn_ok_s & ~(|free_vec_s);

  assign load_s  = free_oh_s & {NSLOT{spawn_ok_s}};
  assign step_s  = slot_active & {NSLOT{tick_s}};
  assign clear_s = grant_oh_s | loss_s | {NSLOT{level_clear}};

  // Kind of the granted slot, OR-muxed from the one-hot grant.
  always_comb begin
    grant_kind_s = 3'd0;
    for (int i = 0; i < NSLOT; i++) begin
      grant_kind_s = grant_kind_s | (slot_kind[KIND_W*i +: KIND_W] & {KIND_W{grant_oh_s[i]}});
    end
  end

  genvar g;
  generate
    for (g = 0; g < NSLOT; g++) begin : g_slot
      gift_slot #(
        .FALL_STEP (FALL_STEP),
        .FLOOR_Y   (FLOOR_Y),
        .GIFT_W    (GIFT_W),
        .GIFT_H    (GIFT_H),
        .PADDLE_H  (PADDLE_H)
      ) u_slot (
        .clock     (clock),
        .reset     (reset),
        .load      (load_s[g]),
        .load_x    (spawn_x),
        .load_y    (spawn_y),
        .load_kind (rand_in[2:0]),
        .step      (step_s[g]),
        .clear     (clear_s[g]),
        .paddle_x  (paddle_x),
        .paddle_y  (paddle_y),
        .paddle_w  (paddle_w),
        .active    (slot_active[g]),
        .kind      (slot_kind[KIND_W*g +: KIND_W]),
        .x         (slot_x[COORD_W*g +: COORD_W]),
        .y         (slot_y[COORD_W*g +: COORD_W]),
        .catch_hit (catch_s[g]),
        .at_floor  (floor_s[g])
      );
    end
  endgenerate

  // Drop pulse register.
  always_ff @(posedge clock) begin
    if (reset) begin
      spawn_drop_r <= 1'b0;
    end else begin
      spawn_drop_r <= drop_s;
    end
  end

  // Effect handshake: a grant (re)loads the port, an ack alone empties it.
  always_ff @(posedge clock) begin
    if (reset) begin
      effect_valid_r <= 1'b0;
      effect_kind_r  <= 3'd0;
    end else if (grant_any_s) begin
      effect_valid_r <= 1'b1;
      effect_kind_r  <= grant_kind_s;
    end else if (effect_ack) begin
      effect_valid_r <= 1'b0;
    end
  end

  assign spawn_drop   = spawn_drop_r;
  assign effect_valid = effect_valid_r;
  assign effect_kind  = effect_kind_r;

`ifdef GIFT_STATS_EN
  logic [CNT_W-1:0] caught_r;
  logic [CNT_W-1:0] lost_r;
  logic [3:0]       loss_num_s;

  // Number of floor losses this cycle.
  always_comb begin
    loss_num_s = 4'd0;
    for (int i = 0; i < NSLOT; i++) begin
      loss_num_s = loss_num_s + {3'd0, loss_s[i]};
    end
  end

  // Saturating statistics, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      caught_r <= 8'd0;
      lost_r   <= 8'd0;
    end else begin
      caught_r <= sat_add(caught_r, {3'd0, grant_any_s});
      lost_r   <= sat_add(lost_r, loss_num_s);
    end
  end

  assign caught_cnt = caught_r;
  assign lost_cnt   = lost_r;
`else
  assign caught_cnt = 8'd0;
  assign lost_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_gift_scheduler.sv
// Self-checking bench for gift_scheduler (NSLOT=4, TICK_DIV=4).
module tb_gift_scheduler;
  localparam int NSLOT    = 4;
  localparam int TICK_DIV = 4;
  localparam int FLOOR_Y  = 480;

  logic        clock = 1'b0;
  logic        reset, enable, level_clear, spawn_req, effect_ack;
  logic [9:0]  spawn_x, spawn_y, paddle_x, paddle_y, paddle_w;
  logic [4:0]  rand_in;
  logic [3:0]  slot_active;
  logic [11:0] slot_kind;
  logic [39:0] slot_x, slot_y;
  logic        spawn_drop, effect_valid;
  logic [2:0]  effect_kind;
  logic [7:0]  caught_cnt, lost_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit m_act[NSLOT];
  int m_x[NSLOT], m_y[NSLOT], m_k[NSLOT];
  int m_div, m_ek, m_caught, m_lost;
  bit m_ev, m_drop;

  gift_scheduler #(.NSLOT(NSLOT), .TICK_DIV(TICK_DIV)) dut (
    .clock(clock), .reset(reset), .enable(enable), .level_clear(level_clear),
    .spawn_req(spawn_req), .spawn_x(spawn_x), .spawn_y(spawn_y), .rand_in(rand_in),
    .paddle_x(paddle_x), .paddle_y(paddle_y), .paddle_w(paddle_w),
    .slot_active(slot_active), .slot_kind(slot_kind), .slot_x(slot_x), .slot_y(slot_y),
    .spawn_drop(spawn_drop), .effect_valid(effect_valid), .effect_kind(effect_kind),
    .effect_ack(effect_ack), .caught_cnt(caught_cnt), .lost_cnt(lost_cnt)
  );

  always #5 clock = ~clock;

  function automatic bit m_catch(int gx, int gy);
    int px, py, pw;
    px = paddle_x; py = paddle_y; pw = paddle_w;
    return (gy + 8 >= py) && (gy <= py + 8) && (gx + 16 > px) && (gx < px + pw);
  endfunction

  function automatic int exp_stat(int v);
`ifdef GIFT_STATS_EN
    return (v > 255) ? 255 : v;
`else
    return 0 * v;
`endif
  endfunction

  // One clock edge: the model computes its next state from the applied inputs.
  task automatic step();
    bit n_act[NSLOT];
    int n_x[NSLOT], n_y[NSLOT], n_k[NSLOT];
    int grant, freei, nloss, n_div, n_ek;
    bit won, tick, n_ev, n_drop;
    for (int i = 0; i < NSLOT; i++) begin
      n_act[i] = m_act[i]; n_x[i] = m_x[i]; n_y[i] = m_y[i]; n_k[i] = m_k[i];
    end
    n_ev = m_ev; n_ek = m_ek; n_drop = 1'b0; n_div = m_div; nloss = 0; grant = -1; freei = -1;
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        n_act[i] = 0; n_x[i] = 0; n_y[i] = 0; n_k[i] = 0;
      end
      n_ev = 0; n_ek = 0; n_div = 0;
    end else begin
      tick = enable && (m_div == TICK_DIV - 1);
      if (enable) n_div = tick ? 0 : m_div + 1;
      if (enable && !level_clear && (!m_ev || effect_ack))
        for (int i = NSLOT - 1; i >= 0; i--)
          if (m_act[i] && m_catch(m_x[i], m_y[i])) grant = i;
      for (int i = NSLOT - 1; i >= 0; i--) if (!m_act[i]) freei = i;
      won = enable && spawn_req && !level_clear && (rand_in[4:3] == 2'b00);
      n_drop = won && (freei < 0);
      for (int i = 0; i < NSLOT; i++) begin
        if (level_clear) n_act[i] = 0;
        else if (i == grant) n_act[i] = 0;
        else if (enable && m_act[i] && m_y[i] >= FLOOR_Y) begin n_act[i] = 0; nloss++; end
        else if (m_act[i] && tick) n_y[i] = (m_y[i] + 1) % 1024;
        else if (won && i == freei) begin
          n_act[i] = 1; n_x[i] = spawn_x; n_y[i] = spawn_y; n_k[i] = rand_in[2:0];
        end
      end
      if (grant >= 0) begin n_ev = 1; n_ek = m_k[grant]; m_caught++; end
      else if (effect_ack) n_ev = 0;
      m_lost += nloss;
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < NSLOT; i++) begin
      m_act[i] = n_act[i]; m_x[i] = n_x[i]; m_y[i] = n_y[i]; m_k[i] = n_k[i];
    end
    m_ev = n_ev; m_ek = n_ek; m_drop = n_drop; m_div = n_div;
    if (reset) begin m_caught = 0; m_lost = 0; end
  endtask

  task automatic spawn(input int sx, input int sy, input logic [4:0] r);
    spawn_req = 1'b1; spawn_x = 10'(sx); spawn_y = 10'(sy); rand_in = r;
    step();
    spawn_req = 1'b0;
  endtask

  task automatic paddle_away();
    paddle_x = 10'd900; paddle_y = 10'd0; paddle_w = 10'd20;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; level_clear = 1'b0; spawn_req = 1'b0; effect_ack = 1'b0;
    spawn_x = 10'd0; spawn_y = 10'd0; rand_in = 5'd0; paddle_away();
    step(); step();
    reset = 1'b0;
    n_cmp++;
    if ({slot_active, slot_kind, slot_x, slot_y} !== 96'd0) begin
      n_bad++; $display("FAIL reset_slots got %h want 0", {slot_active, slot_kind, slot_x, slot_y});
    end
    n_cmp++;
    if ({spawn_drop, effect_valid, effect_kind, caught_cnt, lost_cnt} !== 21'd0) begin
      n_bad++; $display("FAIL reset_outputs got %h want 0",
                        {spawn_drop, effect_valid, effect_kind, caught_cnt, lost_cnt});
    end
  endtask

  task automatic test_spawn();
    enable = 1'b1;
    spawn(100, 50, 5'b00_011);
    n_cmp++;
    if (slot_active !== 4'b0001 || slot_kind[2:0] !== 3'd3 || slot_x[9:0] !== 10'd100 ||
        slot_y[9:0] !== 10'd50) begin
      n_bad++; $display("FAIL spawn_first got act=%b k=%0d x=%0d y=%0d want act=0001 k=3 x=100 y=50",
                        slot_active, slot_kind[2:0], slot_x[9:0], slot_y[9:0]);
    end
    spawn(300, 60, 5'b01_000);
    n_cmp++;
    if (slot_active !== 4'b0001 || spawn_drop !== 1'b0) begin
      n_bad++; $display("FAIL spawn_lose got act=%b drop=%b want 0001 0", slot_active, spawn_drop);
    end
  endtask

  task automatic test_drop();
    spawn(300, 60, 5'b00_001);
    spawn(400, 70, 5'b00_010);
    spawn(500, 80, 5'b00_100);
    n_cmp++;
    if (slot_active !== 4'hF || spawn_drop !== 1'b0) begin
      n_bad++; $display("FAIL fill got act=%b drop=%b want 1111 0", slot_active, spawn_drop);
    end
    spawn(600, 90, 5'b00_111);
    n_cmp++;
    if (slot_active !== 4'hF || spawn_drop !== 1'b1 || slot_kind !== 12'b100_010_001_011) begin
      n_bad++; $display("FAIL drop_pulse got act=%b drop=%b kinds=%b want 1111 1 100010001011",
                        slot_active, spawn_drop, slot_kind);
    end
    step();
    n_cmp++;
    if (spawn_drop !== 1'b0) begin
      n_bad++; $display("FAIL drop_width got %b want 0", spawn_drop);
    end
  endtask

  task automatic test_floor_loss();
    bit seen;
    level_clear = 1'b1; step(); level_clear = 1'b0;
    n_cmp++;
    if (slot_active !== 4'h0) begin
      n_bad++; $display("FAIL clear_all got %b want 0000", slot_active);
    end
    spawn(100, FLOOR_Y - 1, 5'b00_000);
    seen = 1'b0;
    for (int k = 0; k < 2 * TICK_DIV && !seen; k++) begin
      step();
      if (slot_y[9:0] == 10'd480) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || slot_active[0] !== 1'b1) begin
      n_bad++; $display("FAIL floor_reach got seen=%b act=%b want 1 1", seen, slot_active[0]);
    end
    step();
    n_cmp++;
    if (slot_active[0] !== 1'b0 || lost_cnt !== 8'(exp_stat(1))) begin
      n_bad++; $display("FAIL floor_loss got act=%b lost=%0d want 0 %0d",
                        slot_active[0], lost_cnt, exp_stat(1));
    end
  endtask

  task automatic test_catch_priority();
    paddle_away(); effect_ack = 1'b0;
    spawn(200, 295, 5'b00_101);
    spawn(600, 100, 5'b00_001);
    spawn(210, 296, 5'b00_110);
    paddle_x = 10'd200; paddle_y = 10'd300; paddle_w = 10'd40;
    step();
    n_cmp++;
    if (slot_active !== 4'b0110 || effect_valid !== 1'b1 || effect_kind !== 3'd5) begin
      n_bad++; $display("FAIL catch_first got act=%b v=%b k=%0d want 0110 1 5",
                        slot_active, effect_valid, effect_kind);
    end
    step();
    n_cmp++;
    if (slot_active !== 4'b0110 || effect_valid !== 1'b1 || effect_kind !== 3'd5) begin
      n_bad++; $display("FAIL catch_hold got act=%b v=%b k=%0d want 0110 1 5",
                        slot_active, effect_valid, effect_kind);
    end
    effect_ack = 1'b1;
    step();
    n_cmp++;
    if (slot_active !== 4'b0010 || effect_valid !== 1'b1 || effect_kind !== 3'd6) begin
      n_bad++; $display("FAIL catch_ack_grant got act=%b v=%b k=%0d want 0010 1 6",
                        slot_active, effect_valid, effect_kind);
    end
    step();
    n_cmp++;
    if (effect_valid !== 1'b0) begin
      n_bad++; $display("FAIL ack_release got %b want 0", effect_valid);
    end
    effect_ack = 1'b0; paddle_away();
  endtask

  task automatic test_level_clear();
    spawn(700, 100, 5'b00_100);
    paddle_x = 10'd200; paddle_y = 10'd300; paddle_w = 10'd40;
    spawn(200, 300, 5'b00_010);
    step();
    n_cmp++;
    if (slot_active !== 4'b0011 || effect_valid !== 1'b1 || effect_kind !== 3'd2) begin
      n_bad++; $display("FAIL lc_setup got act=%b v=%b k=%0d want 0011 1 2",
                        slot_active, effect_valid, effect_kind);
    end
    paddle_away();
    level_clear = 1'b1;
    spawn(50, 50, 5'b00_000);
    level_clear = 1'b0;
    n_cmp++;
    if (slot_active !== 4'h0 || effect_valid !== 1'b1 || effect_kind !== 3'd2 || spawn_drop !== 1'b0) begin
      n_bad++; $display("FAIL lc_effect got act=%b v=%b k=%0d drop=%b want 0000 1 2 0",
                        slot_active, effect_valid, effect_kind, spawn_drop);
    end
    n_cmp++;
    if (caught_cnt !== 8'(exp_stat(3))) begin
      n_bad++; $display("FAIL caught_count got %0d want %0d", caught_cnt, exp_stat(3));
    end
    effect_ack = 1'b1; step(); effect_ack = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      enable      = ($urandom_range(0, 9) != 0);
      level_clear = ($urandom_range(0, 39) == 0);
      spawn_req   = ($urandom_range(0, 9) < 4);
      rand_in     = 5'($urandom);
      spawn_x     = 10'($urandom_range(0, 300));
      spawn_y     = 10'($urandom_range(430, 479));
      paddle_x    = 10'($urandom_range(0, 300));
      paddle_y    = 10'($urandom_range(430, 490));
      paddle_w    = 10'($urandom_range(20, 100));
      effect_ack  = $urandom_range(0, 1);
      step();
      for (int i = 0; i < NSLOT; i++) begin
        n_cmp++;
        if (slot_active[i] !== m_act[i] || (m_act[i] &&
            {slot_x[10*i +: 10], slot_y[10*i +: 10], slot_kind[3*i +: 3]} !==
            {10'(m_x[i]), 10'(m_y[i]), 3'(m_k[i])})) begin
          n_bad++; $display("FAIL rand_slot%0d cyc %0d got a=%b x=%0d y=%0d k=%0d want a=%b x=%0d y=%0d k=%0d",
                            i, c, slot_active[i], slot_x[10*i +: 10], slot_y[10*i +: 10],
                            slot_kind[3*i +: 3], m_act[i], m_x[i], m_y[i], m_k[i]);
        end
      end
      n_cmp++;
      if (spawn_drop !== m_drop || effect_valid !== m_ev || (m_ev && effect_kind !== 3'(m_ek))) begin
        n_bad++; $display("FAIL rand_port cyc %0d got drop=%b v=%b k=%0d want %b %b %0d",
                          c, spawn_drop, effect_valid, effect_kind, m_drop, m_ev, m_ek);
      end
      n_cmp++;
      if (caught_cnt !== 8'(exp_stat(m_caught)) || lost_cnt !== 8'(exp_stat(m_lost))) begin
        n_bad++; $display("FAIL rand_stats cyc %0d got c=%0d l=%0d want %0d %0d",
                          c, caught_cnt, lost_cnt, exp_stat(m_caught), exp_stat(m_lost));
      end
    end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_drop();
    test_floor_loss();
    test_catch_priority();
    test_level_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
